// File: rtl/counter_updown_mod_pkg.sv
// Shared constants, action encoding and helpers for the up/down modulo counter.
package counter_pkg;

  // Boundary behaviour selector for the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Largest supported prescale ratio and the phase width it needs
  localparam int PRESCALE_MAX   = 256;
  localparam int PRESC_W_MAX    = $clog2(PRESCALE_MAX + 1);

  // What the count register does on a given edge, already priority-resolved
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_STEP  = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_CLEAR = 2'd3
  } act_e;

  // Phase register width for a given prescale ratio
  function automatic int presc_width(input int prescale);
    return $clog2(prescale + 1);
  endfunction

  // Load values above the modulus are pinned to the top of the range
  function automatic logic [31:0] clamp(input logic [31:0] val, input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/counter_updown_mod_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface counter_updown_mod_if #(
  parameter int WIDTH = 10
);
  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_dn, clear, load, load_val, ovf_clr,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up_dn, clear, load, load_val, ovf_clr,
    output count, tc, ovf
  );
endinterface

// File: rtl/counter_updown_mod_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled cycles.
// Phase freezes while en is low and restarts from zero on restart.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int            PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;
  logic          at_last;

  assign at_last = (phase_q == LAST);
  assign tick    = en & at_last;

  // Next phase: restart wins, otherwise advance and wrap on enabled cycles
  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = at_last ? '0 : phase_q + PW'(1);
    end
  end

  // Phase register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with prescaled enable, load/clear,
// wrap-or-saturate boundaries, terminal-count pulse and sticky overflow.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int SATURATE = MODE_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_updown_mod_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;
  logic             restart;
  logic             bound_evt;
  logic [WIDTH-1:0] load_clamped;
  act_e             act;

  assign restart      = bus.clear | bus.load;
  assign load_clamped = WIDTH'(clamp(32'(bus.load_val), 32'(MAX_VAL)));

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (bus.en),
    .restart (restart),
    .tick    (tick)
  );

  // Resolve clear > load > step > hold into a single action
  always_comb begin
    if (bus.clear) begin
      act = ACT_CLEAR;
    end else if (bus.load) begin
      act = ACT_LOAD;
    end else if (tick) begin
      act = ACT_STEP;
    end else begin
      act = ACT_HOLD;
    end
  end

  // Next count and boundary detection; a step at either bound is an event
  always_comb begin
    count_d   = count_q;
    bound_evt = 1'b0;
    unique case (act)
      ACT_CLEAR: count_d = '0;
      ACT_LOAD:  count_d = load_clamped;
      ACT_STEP: begin
        if (bus.up_dn) begin
          if (count_q == MAX_C) begin
            bound_evt = 1'b1;
            count_d   = (SATURATE == MODE_SAT) ? MAX_C : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            bound_evt = 1'b1;
            count_d   = (SATURATE == MODE_SAT) ? '0 : MAX_C;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Status: tc pulses after an event; ovf is sticky and a new event beats ovf_clr
  always_comb begin
    tc_d = bound_evt;
    if (bound_evt) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: five configurations driven side by side,
// each checked every cycle against an arithmetic reference model.
module tb_counter_updown_mod;

  localparam int N = 5;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    int pre;
  } mstate_t;

  // 0: defaults, 1: MAX 9 saturate, 2: MAX 500 prescale 4, 3: MAX 9 wrap, 4: MAX 37 wrap
  int maxv [N] = '{1023, 9, 500, 9, 37};
  bit satv [N] = '{0, 1, 0, 0, 0};
  int prev [N] = '{1, 1, 4, 1, 1};

  logic       clk;
  logic       reset;
  logic       en_r  [N];
  logic       up_r  [N];
  logic       clr_r [N];
  logic       ld_r  [N];
  logic       oc_r  [N];
  logic [9:0] lv_r  [N];
  wire  [9:0] cnt_o [N];
  wire        tc_o  [N];
  wire        ovf_o [N];

  mstate_t ms [N];
  int vectors = 0;
  int fails   = 0;

  counter_updown_mod_if #(.WIDTH(10)) bus_a ();
  counter_updown_mod_if #(.WIDTH(10)) bus_b ();
  counter_updown_mod_if #(.WIDTH(10)) bus_c ();
  counter_updown_mod_if #(.WIDTH(10)) bus_d ();
  counter_updown_mod_if #(.WIDTH(10)) bus_e ();

`define CONN(B, K) \
  assign B.en = en_r[K]; \
  assign B.up_dn = up_r[K]; \
  assign B.clear = clr_r[K]; \
  assign B.load = ld_r[K]; \
  assign B.load_val = lv_r[K]; \
  assign B.ovf_clr = oc_r[K]; \
  assign cnt_o[K] = B.count; \
  assign tc_o[K] = B.tc; \
  assign ovf_o[K] = B.ovf;

  `CONN(bus_a, 0)
  `CONN(bus_b, 1)
  `CONN(bus_c, 2)
  `CONN(bus_d, 3)
  `CONN(bus_e, 4)

  counter_updown_mod u_a (.clk(clk), .reset(reset), .bus(bus_a));
  counter_updown_mod #(.WIDTH(10), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1))
    u_b (.clk(clk), .reset(reset), .bus(bus_b));
  counter_updown_mod #(.WIDTH(10), .MAX_VAL(500), .SATURATE(0), .PRESCALE(4))
    u_c (.clk(clk), .reset(reset), .bus(bus_c));
  counter_updown_mod #(.WIDTH(10), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1))
    u_d (.clk(clk), .reset(reset), .bus(bus_d));
  counter_updown_mod #(.WIDTH(10), .MAX_VAL(37), .SATURATE(0), .PRESCALE(1))
    u_e (.clk(clk), .reset(reset), .bus(bus_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Reference: value moves on the integer line; leaving 0..MAX is the boundary event
  function automatic mstate_t mstep(mstate_t s, int k);
    mstate_t n;
    bit      stp;
    bit      ev;
    int      target;
    int      m;
    n      = s;
    stp    = 0;
    ev     = 0;
    m      = maxv[k] + 1;
    target = 0;
    if (clr_r[k]) begin
      n.cnt = 0;
      n.pre = 0;
    end else if (ld_r[k]) begin
      n.cnt = (int'(lv_r[k]) > maxv[k]) ? maxv[k] : int'(lv_r[k]);
      n.pre = 0;
    end else if (en_r[k]) begin
      n.pre = (s.pre + 1) % prev[k];
      stp   = (n.pre == 0);
    end
    if (stp) begin
      target = up_r[k] ? s.cnt + 1 : s.cnt - 1;
      ev     = (target < 0) || (target > maxv[k]);
      if (!ev)          n.cnt = target;
      else if (satv[k]) n.cnt = s.cnt;
      else              n.cnt = (target + m) % m;
    end
    n.tc  = ev;
    n.ovf = ev ? 1'b1 : (oc_r[k] ? 1'b0 : s.ovf);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < N; k++) ms[k] = mstep(ms[k], k);
    #1;
  endtask

  task automatic idle(int k);
    en_r[k] = 0; up_r[k] = 0; clr_r[k] = 0; ld_r[k] = 0; oc_r[k] = 0; lv_r[k] = '0;
  endtask

  task automatic zero_models();
    for (int k = 0; k < N; k++) ms[k] = '{0, 1'b0, 1'b0, 0};
  endtask

  task automatic rand_inputs(int k);
    en_r[k]  = 1'($urandom_range(0, 3) != 0);
    up_r[k]  = 1'($urandom_range(0, 1));
    clr_r[k] = 1'($urandom_range(0, 19) == 0);
    ld_r[k]  = 1'($urandom_range(0, 15) == 0);
    oc_r[k]  = 1'($urandom_range(0, 7) == 0);
    lv_r[k]  = 10'($urandom_range(0, 1023));
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      idle(k);
      en_r[k] = 1;
      up_r[k] = 1;
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (cnt_o[k] !== 10'd0 || tc_o[k] !== 1'b0 || ovf_o[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: got count=%0d tc=%b ovf=%b want 0/0/0", k, cnt_o[k], tc_o[k], ovf_o[k]);
      end
      idle(k);
    end
    reset = 1'b0;
    zero_models();
  endtask

  task automatic test_up_wrap();
    en_r[0] = 1;
    up_r[0] = 1;
    for (int i = 0; i < 1023; i++) begin
      tick();
      vectors++;
      if (cnt_o[0] !== 10'(ms[0].cnt) || tc_o[0] !== ms[0].tc || ovf_o[0] !== ms[0].ovf) begin
        fails++;
        $display("FAIL up_ramp step %0d: got %0d/%b/%b want %0d/%b/%b", i, cnt_o[0], tc_o[0], ovf_o[0],
                 ms[0].cnt, ms[0].tc, ms[0].ovf);
      end
    end
    vectors++;
    if (cnt_o[0] !== 10'd1023 || tc_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL up_at_max: got count=%0d tc=%b want 1023/0", cnt_o[0], tc_o[0]);
    end
    tick();
    vectors++;
    if (cnt_o[0] !== 10'd0 || tc_o[0] !== 1'b1 || ovf_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL up_wrap: got count=%0d tc=%b ovf=%b want 0/1/1", cnt_o[0], tc_o[0], ovf_o[0]);
    end
    tick();
    vectors++;
    if (cnt_o[0] !== 10'd1 || tc_o[0] !== 1'b0 || ovf_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL tc_one_cycle: got count=%0d tc=%b ovf=%b want 1/0/1", cnt_o[0], tc_o[0], ovf_o[0]);
    end
    for (int i = 0; i < 300; i++) begin
      rand_inputs(0);
      tick();
      vectors++;
      if (cnt_o[0] !== 10'(ms[0].cnt) || tc_o[0] !== ms[0].tc || ovf_o[0] !== ms[0].ovf) begin
        fails++;
        $display("FAIL rand_default %0d: got %0d/%b/%b want %0d/%b/%b", i, cnt_o[0], tc_o[0], ovf_o[0],
                 ms[0].cnt, ms[0].tc, ms[0].ovf);
      end
    end
    idle(0);
  endtask

  task automatic test_saturate();
    int exp_c [4] = '{1, 0, 0, 0};
    bit exp_t [4] = '{0, 0, 1, 1};
    ld_r[1] = 1;
    lv_r[1] = 10'd2;
    tick();
    vectors++;
    if (cnt_o[1] !== 10'd2) begin
      fails++;
      $display("FAIL sat_load: got %0d want 2", cnt_o[1]);
    end
    ld_r[1] = 0;
    en_r[1] = 1;
    up_r[1] = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (cnt_o[1] !== 10'(exp_c[i]) || tc_o[1] !== exp_t[i]) begin
        fails++;
        $display("FAIL sat_down step %0d: got count=%0d tc=%b want %0d/%b", i + 1, cnt_o[1], tc_o[1],
                 exp_c[i], exp_t[i]);
      end
    end
    oc_r[1] = 1;
    tick();
    vectors++;
    if (ovf_o[1] !== 1'b1 || tc_o[1] !== 1'b1 || cnt_o[1] !== 10'd0) begin
      fails++;
      $display("FAIL ovf_set_beats_clr: got ovf=%b tc=%b count=%0d want 1/1/0", ovf_o[1], tc_o[1], cnt_o[1]);
    end
    en_r[1] = 0;
    tick();
    vectors++;
    if (ovf_o[1] !== 1'b0 || tc_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clr: got ovf=%b tc=%b want 0/0", ovf_o[1], tc_o[1]);
    end
    for (int i = 0; i < 200; i++) begin
      rand_inputs(1);
      tick();
      vectors++;
      if (cnt_o[1] !== 10'(ms[1].cnt) || tc_o[1] !== ms[1].tc || ovf_o[1] !== ms[1].ovf) begin
        fails++;
        $display("FAIL rand_sat %0d: got %0d/%b/%b want %0d/%b/%b", i, cnt_o[1], tc_o[1], ovf_o[1],
                 ms[1].cnt, ms[1].tc, ms[1].ovf);
      end
    end
    idle(1);
  endtask

  task automatic test_prescale();
    bit en_seq [5] = '{1, 1, 0, 1, 1};
    int exp_c  [5] = '{0, 0, 0, 0, 1};
    clr_r[2] = 1;
    tick();
    clr_r[2] = 0;
    up_r[2]  = 1;
    for (int i = 0; i < 5; i++) begin
      en_r[2] = en_seq[i];
      tick();
      vectors++;
      if (cnt_o[2] !== 10'(exp_c[i])) begin
        fails++;
        $display("FAIL prescale_seq %0d: got %0d want %0d", i, cnt_o[2], exp_c[i]);
      end
    end
    en_r[2] = 1;
    tick();
    tick();
    ld_r[2] = 1;
    lv_r[2] = 10'd7;
    tick();
    ld_r[2] = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (cnt_o[2] !== ((i == 3) ? 10'd8 : 10'd7)) begin
        fails++;
        $display("FAIL load_restart %0d: got %0d want %0d", i, cnt_o[2], (i == 3) ? 8 : 7);
      end
    end
    tick();
    tick();
    clr_r[2] = 1;
    tick();
    clr_r[2] = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (cnt_o[2] !== ((i == 3) ? 10'd1 : 10'd0)) begin
        fails++;
        $display("FAIL clear_restart %0d: got %0d want %0d", i, cnt_o[2], (i == 3) ? 1 : 0);
      end
    end
    en_r[2] = 0;
    ld_r[2] = 1;
    lv_r[2] = 10'd1000;
    tick();
    vectors++;
    if (cnt_o[2] !== 10'd500) begin
      fails++;
      $display("FAIL load_clamp: got %0d want 500", cnt_o[2]);
    end
    clr_r[2] = 1;
    lv_r[2]  = 10'd5;
    tick();
    vectors++;
    if (cnt_o[2] !== 10'd0) begin
      fails++;
      $display("FAIL clear_over_load: got %0d want 0", cnt_o[2]);
    end
    for (int i = 0; i < 300; i++) begin
      rand_inputs(2);
      if (i % 50 == 0) begin
        ld_r[2]  = 1;
        clr_r[2] = 0;
        lv_r[2]  = up_r[2] ? 10'd499 : 10'd1;
      end
      tick();
      vectors++;
      if (cnt_o[2] !== 10'(ms[2].cnt) || tc_o[2] !== ms[2].tc || ovf_o[2] !== ms[2].ovf) begin
        fails++;
        $display("FAIL rand_prescale %0d: got %0d/%b/%b want %0d/%b/%b", i, cnt_o[2], tc_o[2], ovf_o[2],
                 ms[2].cnt, ms[2].tc, ms[2].ovf);
      end
    end
    idle(2);
  endtask

  task automatic test_random_wrap();
    ld_r[3] = 1;
    lv_r[3] = 10'($urandom_range(0, 9));
    tick();
    ld_r[3] = 0;
    en_r[3] = 1;
    for (int i = 0; i < 25; i++) begin
      up_r[3] = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (cnt_o[3] !== 10'(ms[3].cnt) || tc_o[3] !== ms[3].tc || ovf_o[3] !== ms[3].ovf) begin
        fails++;
        $display("FAIL rand_wrap_step %0d: got %0d/%b/%b want %0d/%b/%b", i, cnt_o[3], tc_o[3], ovf_o[3],
                 ms[3].cnt, ms[3].tc, ms[3].ovf);
      end
    end
    for (int i = 0; i < 200; i++) begin
      rand_inputs(3);
      tick();
      vectors++;
      if (cnt_o[3] !== 10'(ms[3].cnt) || tc_o[3] !== ms[3].tc || ovf_o[3] !== ms[3].ovf) begin
        fails++;
        $display("FAIL rand_wrap_full %0d: got %0d/%b/%b want %0d/%b/%b", i, cnt_o[3], tc_o[3], ovf_o[3],
                 ms[3].cnt, ms[3].tc, ms[3].ovf);
      end
    end
    idle(3);
  endtask

  task automatic test_async_reset();
    ld_r[4] = 1;
    lv_r[4] = 10'd0;
    tick();
    ld_r[4] = 0;
    en_r[4] = 1;
    up_r[4] = 0;
    tick();
    en_r[4] = 0;
    vectors++;
    if (cnt_o[4] !== 10'd37 || tc_o[4] !== 1'b1 || ovf_o[4] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_state: got count=%0d tc=%b ovf=%b want 37/1/1", cnt_o[4], tc_o[4], ovf_o[4]);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (cnt_o[4] !== 10'd0 || tc_o[4] !== 1'b0 || ovf_o[4] !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got count=%0d tc=%b ovf=%b want 0/0/0", cnt_o[4], tc_o[4], ovf_o[4]);
    end
    zero_models();
    #1 reset = 1'b0;
    en_r[4] = 1;
    up_r[4] = 1;
    tick();
    vectors++;
    if (cnt_o[4] !== 10'd1 || tc_o[4] !== 1'b0 || ovf_o[4] !== 1'b0) begin
      fails++;
      $display("FAIL resume_after_reset: got count=%0d tc=%b ovf=%b want 1/0/0", cnt_o[4], tc_o[4], ovf_o[4]);
    end
    idle(4);
    tick();
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (cnt_o[k] !== 10'(ms[k].cnt) || tc_o[k] !== ms[k].tc || ovf_o[k] !== ms[k].ovf) begin
        fails++;
        $display("FAIL post_reset_all[%0d]: got %0d/%b/%b want %0d/%b/%b", k, cnt_o[k], tc_o[k], ovf_o[k],
                 ms[k].cnt, ms[k].tc, ms[k].ovf);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    zero_models();
    for (int k = 0; k < N; k++) idle(k);
    test_reset();
    test_up_wrap();
    test_saturate();
    test_prescale();
    test_random_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
